// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and the display-source enum for the 7-segment
// scan controller and its slot timer.
package seg7_pkg;

    localparam int unsigned SEG7_DIGITS = 4;
    localparam int unsigned NIBBLE_W    = 4;
    localparam int unsigned IDX_W       = $clog2(SEG7_DIGITS);

    typedef enum logic {
        SRC_SYS = 1'b0,
        SRC_DBG = 1'b1
    } src_e;

endpackage

// File: rtl/seg7_slot_timer.sv
// seg7_slot_timer: digit-slot sequencer for the multiplexed display.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   idx         - index of the digit slot currently being scanned
//   slot_wrap   - high on the last cycle of a slot
//   frame_wrap  - high on the last cycle of the last slot of a frame
//   in_blank    - high during the dead-time cycles at the start of a slot
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 50000,
    parameter int unsigned BLANK_CYC = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] idx,
    output logic             slot_wrap,
    output logic             frame_wrap,
    output logic             in_blank
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        slot_wrap  = (slot_cnt_q == CNT_W'(CLK_DIV - 1));
        frame_wrap = slot_wrap && (idx_q == IDX_W'(SEG7_DIGITS - 1));
        in_blank   = (slot_cnt_q < CNT_W'(BLANK_CYC));
        slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + CNT_W'(1);
        // SEG7_DIGITS is a power of two, so the index wraps mod 4 by overflow
        idx_d      = slot_wrap ? idx_q + IDX_W'(1) : idx_q;
        idx        = idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q <= '0;
            idx_q      <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: scan scheduler for a 4-digit multiplexed 7-segment display.
// Takes a tear-free per-frame snapshot of either the system or the debug
// source (debug has fixed priority, sampled only at frame boundaries), then
// scans the digits with blanking dead time and PWM brightness.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   en                    - display enable (0 blanks an, counters keep running)
//   sys_data, sys_dp      - system value / decimal points, nibble/bit i -> digit i
//   dbg_req, dbg_data     - debug ownership request (level) / debug value
//   brightness            - PWM duty level, all-ones = full on
//   an                    - one-hot anode select, 0 = blank
//   digit, dp             - nibble and decimal point of the active digit
//   src_sel               - owner of the current frame (0 sys, 1 debug)
//   dbg_ack, frame_start  - 1-cycle pulses at the snapshot edge
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 50000,
    parameter int unsigned BLANK_CYC = 64,
    parameter int unsigned BRIGHT_W  = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic [SEG7_DIGITS*NIBBLE_W-1:0]   sys_data,
    input  logic [SEG7_DIGITS-1:0]            sys_dp,
    input  logic                              dbg_req,
    input  logic [SEG7_DIGITS*NIBBLE_W-1:0]   dbg_data,
    input  logic [BRIGHT_W-1:0]               brightness,
    output logic [SEG7_DIGITS-1:0]            an,
    output logic [NIBBLE_W-1:0]               digit,
    output logic                              dp,
    output logic                              src_sel,
    output logic                              dbg_ack,
    output logic                              frame_start
);

    if (CLK_DIV <= BLANK_CYC) begin : g_bad_cfg
        $error("seg7_scan_ctrl: CLK_DIV must exceed BLANK_CYC");
    end

    logic [IDX_W-1:0] idx;
    logic             slot_wrap, frame_wrap, in_blank, boundary;

    logic [SEG7_DIGITS-1:0][NIBBLE_W-1:0] shadow_q, shadow_d;
    logic [SEG7_DIGITS-1:0]               dp_shadow_q, dp_shadow_d;
    logic [BRIGHT_W-1:0]                  bright_q, bright_d;
    logic [BRIGHT_W-1:0]                  pwm_cnt_q, pwm_cnt_d;
    logic                                 load_pend_q, load_pend_d;
    src_e                                 src_q, src_d;
    logic [SEG7_DIGITS-1:0]               an_q, an_d;
    logic [NIBBLE_W-1:0]                  digit_q, digit_d;
    logic                                 dp_q, dp_d;
    logic                                 dbg_ack_q, dbg_ack_d;
    logic                                 frame_start_q, frame_start_d;

    seg7_slot_timer #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .idx        (idx),
        .slot_wrap  (slot_wrap),
        .frame_wrap (frame_wrap),
        .in_blank   (in_blank)
    );

    // load_pend forces the first snapshot on the first edge after reset
    assign boundary = frame_wrap || load_pend_q;

    always_comb begin
        shadow_d    = shadow_q;
        dp_shadow_d = dp_shadow_q;
        bright_d    = bright_q;
        src_d       = src_q;
        load_pend_d = load_pend_q;
        pwm_cnt_d   = pwm_cnt_q + BRIGHT_W'(1);

        if (boundary) begin
            shadow_d    = dbg_req ? dbg_data : sys_data;
            dp_shadow_d = dbg_req ? '0 : sys_dp;
            src_d       = dbg_req ? SRC_DBG : SRC_SYS;
            bright_d    = brightness;
            load_pend_d = 1'b0;
        end

        frame_start_d = boundary;
        dbg_ack_d     = boundary && dbg_req;
        digit_d       = shadow_q[idx];
        dp_d          = dp_shadow_q[idx];
        if (en && !in_blank && (pwm_cnt_q <= bright_q)) begin
            an_d = SEG7_DIGITS'(1) << idx;
        end else begin
            an_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q      <= '0;
            dp_shadow_q   <= '0;
            bright_q      <= '0;
            pwm_cnt_q     <= '0;
            load_pend_q   <= 1'b1;
            src_q         <= SRC_SYS;
            an_q          <= '0;
            digit_q       <= '0;
            dp_q          <= 1'b0;
            dbg_ack_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            dp_shadow_q   <= dp_shadow_d;
            bright_q      <= bright_d;
            pwm_cnt_q     <= pwm_cnt_d;
            load_pend_q   <= load_pend_d;
            src_q         <= src_d;
            an_q          <= an_d;
            digit_q       <= digit_d;
            dp_q          <= dp_d;
            dbg_ack_q     <= dbg_ack_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign digit       = digit_q;
    assign dp          = dp_q;
    assign src_sel     = (src_q == SRC_DBG);
    assign dbg_ack     = dbg_ack_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: scoreboard bench for seg7_scan_ctrl. The driver computes
// the expected outputs for each upcoming clock edge from elapsed time since
// reset release and pushes them; the monitor pops and compares after each edge.
module tb_seg7_scan_ctrl;

    localparam int unsigned CLK_DIV   = 8;
    localparam int unsigned BLANK_CYC = 2;
    localparam int unsigned BRIGHT_W  = 2;
    localparam int unsigned FRAME     = CLK_DIV * 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                en = 1'b1;
    logic [15:0]         sys_data = '0;
    logic [3:0]          sys_dp = '0;
    logic                dbg_req = 1'b0;
    logic [15:0]         dbg_data = '0;
    logic [BRIGHT_W-1:0] brightness = '1;
    logic [3:0]          an;
    logic [3:0]          digit;
    logic                dp, src_sel, dbg_ack, frame_start;

    seg7_scan_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC),
        .BRIGHT_W  (BRIGHT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sys_data    (sys_data),
        .sys_dp      (sys_dp),
        .dbg_req     (dbg_req),
        .dbg_data    (dbg_data),
        .brightness  (brightness),
        .an          (an),
        .digit       (digit),
        .dp          (dp),
        .src_sel     (src_sel),
        .dbg_ack     (dbg_ack),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] digit;
        logic       dp;
        logic       src;
        logic       ack;
        logic       fs;
    } obs_t;

    obs_t        exp_q[$];
    int unsigned evn_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    // reference model state: edges since reset release plus the latched frame
    int unsigned n = 0;
    logic [15:0] m_shadow = '0;
    logic [3:0]  m_dp = '0;
    logic        m_src = 1'b0;
    int unsigned m_bright = 0;
    logic [3:0]  last_an = '0;

    // Predict the outputs after the next posedge from the inputs now applied.
    task automatic tick();
        obs_t        e;
        int unsigned prev, s, i, pw;
        bit          bnd;
        e = '0;
        if (!rst_n) begin
            n = 0;
            m_shadow = '0;
            m_dp = '0;
            m_src = 1'b0;
            m_bright = 0;
        end else begin
            n++;
            prev = n - 1;
            s  = prev % CLK_DIV;
            i  = (prev / CLK_DIV) % 4;
            pw = prev % (1 << BRIGHT_W);
            e.an    = (en && s >= BLANK_CYC && pw <= m_bright) ? 4'(1 << i) : 4'h0;
            e.digit = 4'(m_shadow >> (4 * i));
            e.dp    = m_dp[i];
            bnd = (n == 1) || (n % FRAME == 0);
            if (bnd) begin
                m_shadow = dbg_req ? dbg_data : sys_data;
                m_dp     = dbg_req ? 4'h0 : sys_dp;
                m_src    = dbg_req;
                m_bright = brightness;
            end
            e.src = m_src;
            e.ack = bnd && dbg_req;
            e.fs  = bnd;
        end
        last_an = e.an;
        exp_q.push_back(e);
        evn_q.push_back(n);
        @(negedge clk);
    endtask

    task automatic run(input int unsigned k);
        repeat (k) tick();
    endtask

    // monitor
    initial begin
        obs_t        e, a;
        int unsigned en_idx;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                en_idx = evn_q.pop_front();
                a.an = an; a.digit = digit; a.dp = dp;
                a.src = src_sel; a.ack = dbg_ack; a.fs = frame_start;
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs@edge%0d: got an=%b digit=%h dp=%b src=%b ack=%b fs=%b, expected an=%b digit=%h dp=%b src=%b ack=%b fs=%b",
                             en_idx, a.an, a.digit, a.dp, a.src, a.ack, a.fs,
                             e.an, e.digit, e.dp, e.src, e.ack, e.fs);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver
    initial begin
        int unsigned k;
        // reset and basic scan
        rst_n = 1'b0; en = 1'b1; brightness = 2'd3;
        sys_data = 16'h1234; sys_dp = 4'b0001; dbg_req = 1'b0; dbg_data = 16'h0000;
        run(3);
        rst_n = 1'b1;
        run(2 * FRAME + 6);

        // debug takes a frame mid-frame, then releases
        dbg_data = 16'hBEEF;
        run(10);
        dbg_req = 1'b1;
        run(2 * FRAME);
        dbg_req = 1'b0;
        run(2 * FRAME);

        // brightness levels
        brightness = 2'd0;
        run(2 * FRAME);
        brightness = 2'd1;
        run(2 * FRAME);
        brightness = 2'd3;
        run(FRAME);

        // enable pulse mid-slot
        run(3);
        en = 1'b0;
        run(5);
        en = 1'b1;
        run(FRAME);

        // system value change during slot 2
        k = 0;
        while ((n % FRAME) != 18 && k < 2 * FRAME) begin
            tick();
            k++;
        end
        sys_data = 16'hFFFF;
        run(2 * FRAME);

        // randomized traffic
        for (int c = 0; c < 640; c++) begin
            en         = ($urandom_range(0, 15) != 0);
            sys_data   = 16'($urandom);
            sys_dp     = 4'($urandom);
            dbg_data   = 16'($urandom);
            brightness = BRIGHT_W'($urandom);
            if ($urandom_range(0, 39) == 0) dbg_req = ~dbg_req;
            tick();
        end

        // asynchronous reset while a digit is lit and debug owns the frame
        en = 1'b1; brightness = 2'd3; dbg_req = 1'b1;
        run(FRAME + 1);
        k = 0;
        while (last_an == 4'h0 && k < 100) begin
            tick();
            k++;
        end
        vectors++;
        if (last_an == 4'h0) begin
            miscompares++;
            $display("FAIL lit-wait: an stayed %b, required non-zero before reset", last_an);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({an, digit, dp, src_sel, dbg_ack, frame_start} !== 12'h000) begin
            miscompares++;
            $display("FAIL async-reset: got an=%b digit=%h dp=%b src=%b ack=%b fs=%b, required all 0",
                     an, digit, dp, src_sel, dbg_ack, frame_start);
        end
        dbg_req = 1'b0;
        sys_data = 16'hA5C3; sys_dp = 4'b1010;
        run(3);
        rst_n = 1'b1;
        run(FRAME + 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
